ps2_key_decoder: RTL

- Parametrised keyboard front end between PS2_Controller and the game FSMs.
- Parses PS/2 set-2 scan-code byte streams: make, F0 break, and E0 extended prefixes.
- Maps up to NUM_KEYS configured codes to per-key held levels and press/release pulses.
- Adds a typematic auto-repeat engine for movement keys, so gameplay FSMs consume clean one-cycle pulses instead of a sticky last-byte register.

---
 rtl/ps2_key_decoder.sv | 103 ++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scan-code parser with per-key held/press/release/auto-repeat; `define PS2_TYPEMATIC_FILTER_EN to ignore makes of held keys
module ps2_key_decoder #(
  parameter int NUM_KEYS = 9,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h01D, 9'h01B, 9'h023, 9'h01C, 9'h026, 9'h01E, 9'h016, 9'h066, 9'h05A},
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK = 9'b0_1110_0000,
  parameter int DELAY_CYCLES = 12_500_000,
  parameter int RATE_CYCLES = 2_500_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [7:0]          last_code
);
  localparam int CNT_W = $clog2((DELAY_CYCLES > RATE_CYCLES ? DELAY_CYCLES : RATE_CYCLES) + 1);
  localparam int TW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, state_nxt;
  logic is_e0, is_f0, pfx, make_ev, brk_ev, ext;
  logic [NUM_KEYS-1:0] match, press_ev, rel_ev, rep_hit, rep_nxt;
  logic [TW-1:0] target, sel;
  logic [CNT_W-1:0] cnt;
  logic active, tgt_rel, fire;
  assign is_e0 = received_data == 8'hE0;
  assign is_f0 = received_data == 8'hF0;
  assign pfx = is_e0 | is_f0;
  always_comb begin
    state_nxt = state;
    make_ev = 1'b0;
    brk_ev = 1'b0;
    ext = 1'b0;
    if (received_data_en)
      case (state)
        IDLE: begin
          state_nxt = is_e0 ? EXT : is_f0 ? BRK : IDLE;
          make_ev = !pfx;
        end
        EXT: begin
          state_nxt = is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE;
          make_ev = !pfx;
          ext = 1'b1;
        end
        BRK: begin
          state_nxt = pfx ? BRK : IDLE;
          brk_ev = !pfx;
        end
        EXT_BRK: begin
          state_nxt = pfx ? EXT_BRK : IDLE;
          brk_ev = !pfx;
          ext = 1'b1;
        end
      endcase
  end
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) match[i] = KEY_CODES[9*i +: 9] == {ext, received_data};
  end
`ifdef PS2_TYPEMATIC_FILTER_EN
  assign press_ev = make_ev ? match & ~key_held : '0;
`else
  assign press_ev = make_ev ? match : '0;
`endif
  assign rel_ev = brk_ev ? match & key_held : '0;
  assign rep_hit = press_ev & REPEAT_MASK;
  always_comb begin
    sel = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (rep_hit[i]) sel = TW'(i);
  end
  // a release or a fresh press on the same edge wins over a due repeat
  assign tgt_rel = active & rel_ev[target];
  assign fire = active & (cnt == CNT_W'(1)) & ~tgt_rel & ~|rep_hit;
  assign rep_nxt = fire ? NUM_KEYS'(1) << target : '0;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      key_held <= '0;
      key_press <= '0;
      key_release <= '0;
      key_repeat <= '0;
      last_code <= '0;
      active <= 1'b0;
      target <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      key_held <= (key_held | (make_ev ? match : '0)) & ~rel_ev;
      key_press <= press_ev;
      key_release <= rel_ev;
      key_repeat <= rep_nxt;
      if (received_data_en && !pfx) last_code <= received_data;
      if (|rep_hit) begin
        active <= 1'b1;
        target <= sel;
        cnt <= CNT_W'(DELAY_CYCLES);
      end else if (tgt_rel) active <= 1'b0;
      else if (active) cnt <= cnt == CNT_W'(1) ? CNT_W'(RATE_CYCLES) : cnt - CNT_W'(1);
    end
  end
endmodule
